// File: rtl/id_decode_stage.sv
// RV32 instruction-decode stage: decodes into EX/MEM/WB control, builds the immediate and
// registers the result behind a valid/ready handshake. Optional counters: ID_PERF_CNT_EN.
module id_decode_stage #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_W     = 5,
   parameter int LOAD_USE_CHECK = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [31:0]             i_instr,
   input  logic [XLEN-1:0]         i_pc,
   input  logic                    i_flush,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [XLEN-1:0]         o_pc,
   output logic [XLEN-1:0]         o_imm,
   output logic [REG_ADDR_W-1:0]   o_rdReg1,
   output logic [REG_ADDR_W-1:0]   o_rdReg2,
   output logic [13:0]             o_ctrlEX,
   output logic [3:0]              o_ctrlMEM,
   output logic [REG_ADDR_W+1:0]   o_ctrlWB,
   output logic                    o_illegal
`ifdef ID_PERF_CNT_EN
   ,
   output logic [31:0]             o_instrCnt,
   output logic [31:0]             o_bubbleCnt
`endif
);

   logic [1:0]            alu_op, alu_src, wb2;
   logic [3:0]            mem_c;
   logic                  use_rd, use_rs1, use_rs2, use_f3, use_f7, known, e_bad;
   logic [XLEN-1:0]       imm_sel;
   logic [XLEN-1:0]       imm_d;
   logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
   logic [13:0]           ex_d;
   logic [3:0]            mem_d;
   logic [REG_ADDR_W+1:0] wb_d;
   logic                  ill_d;

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{(XLEN-11){i_instr[31]}}, i_instr[30:20]};
   assign imm_s = {{(XLEN-11){i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
   assign imm_b = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){i_instr[31]}}, i_instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      alu_op = 2'b00; alu_src = 2'b00; mem_c = 4'b0000; wb2 = 2'b00;
      use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_f3 = 1'b0; use_f7 = 1'b0;
      imm_sel = '0; known = 1'b1;
      case (i_instr[6:0])
         7'b0110011: begin alu_op = 2'b10; wb2 = 2'b10;
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1; end
         7'b0010011: begin alu_op = 2'b10; alu_src = 2'b01; wb2 = 2'b10;
            use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; imm_sel = imm_i;
            // Only the shift-immediates carry a meaningful func7.
            use_f7 = (i_instr[14:12] == 3'b001) || (i_instr[14:12] == 3'b101); end
         7'b0000011: begin alu_src = 2'b01; mem_c = 4'b0010; wb2 = 2'b11;
            use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; imm_sel = imm_i; end
         7'b0100011: begin alu_src = 2'b01; mem_c = 4'b0001;
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; imm_sel = imm_s; end
         7'b1100011: begin alu_op = 2'b01; mem_c = 4'b0100;
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; imm_sel = imm_b; end
         7'b0110111: begin alu_src = 2'b01; wb2 = 2'b10; use_rd = 1'b1; imm_sel = imm_u; end
         7'b0010111: begin alu_src = 2'b11; wb2 = 2'b10; use_rd = 1'b1; imm_sel = imm_u; end
         7'b1101111: begin alu_src = 2'b10; mem_c = 4'b1000; wb2 = 2'b10;
            use_rd = 1'b1; imm_sel = imm_j; end
         7'b1100111: begin alu_src = 2'b10; mem_c = 4'b1100; wb2 = 2'b10;
            use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; imm_sel = imm_i; end
         default: known = 1'b0;
      endcase
      e_bad = 1'b0;
      if (REG_ADDR_W == 4)
         e_bad = (use_rd && i_instr[11]) || (use_rs1 && i_instr[19]) || (use_rs2 && i_instr[24]);
      ill_d = !known || e_bad;
   end

   always_comb begin
      ex_d  = '0; mem_d = '0; wb_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0; imm_d = '0;
      if (!ill_d) begin
         rd_d  = use_rd  ? i_instr[7 +: REG_ADDR_W]  : '0;
         rs1_d = use_rs1 ? i_instr[15 +: REG_ADDR_W] : '0;
         rs2_d = use_rs2 ? i_instr[20 +: REG_ADDR_W] : '0;
         ex_d  = {alu_op, alu_src, use_f3 ? i_instr[14:12] : 3'b000, use_f7 ? i_instr[31:25] : 7'b0};
         mem_d = mem_c;
         wb_d  = {wb2, rd_d};
         imm_d = imm_sel;
      end
   end

   logic                  valid_q, ill_q;
   logic [XLEN-1:0]       pc_q, imm_q;
   logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
   logic [13:0]           ex_q;
   logic [3:0]            mem_q;
   logic [REG_ADDR_W+1:0] wb_q;
   logic                  adv, hazard, capture, bubble;

   assign rd_q = wb_q[REG_ADDR_W-1:0];
   // Unused rs fields decode to 0 and rd==0 is excluded, so x0 never stalls.
   assign hazard  = (LOAD_USE_CHECK != 0) && valid_q && mem_q[1] && (rd_q != '0) && i_valid &&
                    ((rd_q == rs1_d) || (rd_q == rs2_d));
   assign adv     = !valid_q || i_ready;
   assign o_ready = i_flush || (adv && !hazard);
   assign capture = !i_flush && adv && i_valid && !hazard;
   assign bubble  = !i_flush && adv && hazard;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0; ill_q <= 1'b0; pc_q <= '0; imm_q <= '0;
         rs1_q <= '0; rs2_q <= '0; ex_q <= '0; mem_q <= '0; wb_q <= '0;
      end else begin
         if (i_flush)  valid_q <= 1'b0;
         else if (adv) valid_q <= i_valid && !hazard;
         if (capture) begin
            pc_q <= i_pc; imm_q <= imm_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
            ex_q <= ex_d; mem_q <= mem_d; wb_q <= wb_d; ill_q <= ill_d;
         end
      end
   end

   assign o_valid = valid_q;  assign o_pc = pc_q;       assign o_imm = imm_q;
   assign o_rdReg1 = rs1_q;   assign o_rdReg2 = rs2_q;  assign o_ctrlEX = ex_q;
   assign o_ctrlMEM = mem_q;  assign o_ctrlWB = wb_q;   assign o_illegal = ill_q;

`ifdef ID_PERF_CNT_EN
   logic [31:0] icnt_q, bcnt_q;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         icnt_q <= '0; bcnt_q <= '0;
      end else begin
         if (capture) icnt_q <= icnt_q + 32'd1;
         if (bubble)  bcnt_q <= bcnt_q + 32'd1;
      end
   end
   assign o_instrCnt  = icnt_q;
   assign o_bubbleCnt = bcnt_q;
`else
   // Counters compiled out; bubble is only consumed by the perf logic.
   logic unused_bubble;
   assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomized bench for id_decode_stage: three instances (RV32I, RV32E, no load-use check)
// share stimulus and are checked every cycle against a table-driven behavioural model.
module tb_id_decode_stage;
   logic i_clk = 1'b0, i_rst, i_valid, i_flush, i_ready;
   logic [31:0] i_instr, i_pc;
   always #5 i_clk = ~i_clk;

   logic a_ordy, a_ov, a_ill, e_ordy, e_ov, e_ill, n_ordy, n_ov, n_ill;
   logic [31:0] a_pc, a_imm, e_pc, e_imm, n_pc, n_imm;
   logic [4:0] a_rs1, a_rs2, n_rs1, n_rs2;
   logic [3:0] e_rs1, e_rs2, a_mem, e_mem, n_mem;
   logic [13:0] a_ex, e_ex, n_ex;
   logic [6:0] a_wb, n_wb;
   logic [5:0] e_wb;
`ifdef ID_PERF_CNT_EN
   logic [31:0] a_ic, a_bc, e_ic, e_bc, n_ic, n_bc;
`endif

   id_decode_stage #(.XLEN(32), .REG_ADDR_W(5), .LOAD_USE_CHECK(1)) dut_a (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(a_ordy), .i_instr(i_instr),
      .i_pc(i_pc), .i_flush(i_flush), .o_valid(a_ov), .i_ready(i_ready), .o_pc(a_pc),
      .o_imm(a_imm), .o_rdReg1(a_rs1), .o_rdReg2(a_rs2), .o_ctrlEX(a_ex), .o_ctrlMEM(a_mem),
      .o_ctrlWB(a_wb), .o_illegal(a_ill)
`ifdef ID_PERF_CNT_EN
      , .o_instrCnt(a_ic), .o_bubbleCnt(a_bc)
`endif
   );
   id_decode_stage #(.XLEN(32), .REG_ADDR_W(4), .LOAD_USE_CHECK(1)) dut_e (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(e_ordy), .i_instr(i_instr),
      .i_pc(i_pc), .i_flush(i_flush), .o_valid(e_ov), .i_ready(i_ready), .o_pc(e_pc),
      .o_imm(e_imm), .o_rdReg1(e_rs1), .o_rdReg2(e_rs2), .o_ctrlEX(e_ex), .o_ctrlMEM(e_mem),
      .o_ctrlWB(e_wb), .o_illegal(e_ill)
`ifdef ID_PERF_CNT_EN
      , .o_instrCnt(e_ic), .o_bubbleCnt(e_bc)
`endif
   );
   id_decode_stage #(.XLEN(32), .REG_ADDR_W(5), .LOAD_USE_CHECK(0)) dut_n (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(n_ordy), .i_instr(i_instr),
      .i_pc(i_pc), .i_flush(i_flush), .o_valid(n_ov), .i_ready(i_ready), .o_pc(n_pc),
      .o_imm(n_imm), .o_rdReg1(n_rs1), .o_rdReg2(n_rs2), .o_ctrlEX(n_ex), .o_ctrlMEM(n_mem),
      .o_ctrlWB(n_wb), .o_illegal(n_ill)
`ifdef ID_PERF_CNT_EN
      , .o_instrCnt(n_ic), .o_bubbleCnt(n_bc)
`endif
   );

   typedef struct {
      logic [31:0] pc, imm; logic [4:0] rs1, rs2; logic [13:0] ex;
      logic [3:0] mem; logic [6:0] wb; logic ill;
   } dec_t;

   int n_pass = 0, n_tot = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      else n_pass++;
   endtask

   // Reference decode straight from the opcode table; immediates via arithmetic shifts/masks.
   function automatic dec_t dec(input logic [31:0] in, input logic [31:0] pc, input bit e);
      dec_t r; logic [9:0] row; bit ud, u1, u2, uf3, uf7, known; logic [31:0] t, imm;
      r = '{default: 0}; r.pc = pc;
      row = '0; ud = 0; u1 = 0; u2 = 0; uf3 = 0; uf7 = 0; known = 1; imm = 0;
      t = $signed(in) >>> 20;
      case (in[6:0])
         7'b0110011: begin row = 10'b10_00_0000_10; ud = 1; u1 = 1; u2 = 1; uf3 = 1; uf7 = 1; end
         7'b0010011: begin row = 10'b10_01_0000_10; ud = 1; u1 = 1; uf3 = 1; imm = t;
                           uf7 = (in[14:12] == 3'b001) || (in[14:12] == 3'b101); end
         7'b0000011: begin row = 10'b00_01_0010_11; ud = 1; u1 = 1; uf3 = 1; imm = t; end
         7'b0100011: begin row = 10'b00_01_0001_00; u1 = 1; u2 = 1; uf3 = 1;
                           imm = (t & 32'hFFFFFFE0) | 32'(in[11:7]); end
         7'b1100011: begin row = 10'b01_00_0100_00; u1 = 1; u2 = 1; uf3 = 1;
                           imm = (t & 32'hFFFFF7E0) | (32'(in[7]) << 11) | (32'(in[11:8]) << 1); end
         7'b0110111: begin row = 10'b00_01_0000_10; ud = 1; imm = in & 32'hFFFFF000; end
         7'b0010111: begin row = 10'b00_11_0000_10; ud = 1; imm = in & 32'hFFFFF000; end
         7'b1101111: begin row = 10'b00_10_1000_10; ud = 1;
                           imm = (t & 32'hFFF007FE) | (in & 32'h000FF000) | (32'(in[20]) << 11); end
         7'b1100111: begin row = 10'b00_10_1100_10; ud = 1; u1 = 1; uf3 = 1; imm = t; end
         default: known = 0;
      endcase
      r.ill = !known || (e && ((ud && in[11]) || (u1 && in[19]) || (u2 && in[24])));
      if (!r.ill) begin
         r.imm = imm;
         r.rs1 = u1 ? in[19:15] : 5'd0;
         r.rs2 = u2 ? in[24:20] : 5'd0;
         r.ex  = {row[9:6], uf3 ? in[14:12] : 3'b0, uf7 ? in[31:25] : 7'b0};
         r.mem = row[5:2];
         r.wb  = {row[1:0], ud ? in[11:7] : 5'd0};
      end
      return r;
   endfunction

   // Model state per instance: 0 = RV32I, 1 = RV32E, 2 = no load-use check.
   dec_t mo[3];
   bit mv[3] = '{0, 0, 0};
   bit lc[3] = '{1, 1, 0};
   bit ee[3] = '{0, 1, 0};
   int unsigned icnt[3] = '{0, 0, 0}, bcnt[3] = '{0, 0, 0};
   logic [31:0] sbq[$];

   function automatic bit haz(int k);
      dec_t d; d = dec(i_instr, i_pc, ee[k]);
      return lc[k] && mv[k] && mo[k].mem[1] && (mo[k].wb[4:0] != 0) && i_valid &&
             ((mo[k].wb[4:0] == d.rs1) || (mo[k].wb[4:0] == d.rs2));
   endfunction

   function automatic dec_t mk(logic [31:0] pc, imm, logic [4:0] r1, r2, logic [13:0] ex,
                               logic [3:0] mem, logic [6:0] wb, logic ill);
      dec_t r; r.pc = pc; r.imm = imm; r.rs1 = r1; r.rs2 = r2; r.ex = ex; r.mem = mem;
      r.wb = wb; r.ill = ill; return r;
   endfunction

   task automatic cmp(input int k, input string nm, input logic rdy, input logic v, input dec_t a);
      chk({nm, "_ready"}, rdy, i_flush || ((!mv[k] || i_ready) && !haz(k)));
      chk({nm, "_valid"}, v, mv[k]);
      if (mv[k] && v) begin
         chk({nm, "_pc"}, a.pc, mo[k].pc);
         chk({nm, "_ctrl"}, {a.ex, a.mem, a.wb}, {mo[k].ex, mo[k].mem, mo[k].wb});
         chk({nm, "_rs"}, {a.rs1, a.rs2}, {mo[k].rs1, mo[k].rs2});
         chk({nm, "_illegal"}, a.ill, mo[k].ill);
         if (!mo[k].ill) chk({nm, "_imm"}, a.imm, mo[k].imm);
      end
   endtask

   initial forever begin
      @(negedge i_clk);
      if (i_rst) begin
         for (int k = 0; k < 3; k++) begin
            mv[k] = 0; mo[k] = '{default: 0}; icnt[k] = 0; bcnt[k] = 0;
         end
         sbq.delete();
         chk("rst_valid", a_ov, 0);
         chk("rst_data", {a_pc, a_imm}, 0);
         chk("rst_ctrl", {a_ex, a_mem, a_wb, a_rs1, a_rs2, a_ill}, 0);
      end else begin
         bit h, adv; logic [31:0] head;
         cmp(0, "a", a_ordy, a_ov, mk(a_pc, a_imm, a_rs1, a_rs2, a_ex, a_mem, a_wb, a_ill));
         cmp(1, "e", e_ordy, e_ov, mk(e_pc, e_imm, {1'b0, e_rs1}, {1'b0, e_rs2}, e_ex, e_mem,
                                     {e_wb[5:4], 1'b0, e_wb[3:0]}, e_ill));
         cmp(2, "n", n_ordy, n_ov, mk(n_pc, n_imm, n_rs1, n_rs2, n_ex, n_mem, n_wb, n_ill));
`ifdef ID_PERF_CNT_EN
         chk("cnt_a", {a_ic, a_bc}, {icnt[0], bcnt[0]});
         chk("cnt_e", {e_ic, e_bc}, {icnt[1], bcnt[1]});
         chk("cnt_n", {n_ic, n_bc}, {icnt[2], bcnt[2]});
`endif
         // In-order scoreboard on the main instance: accepted PCs must leave once, in order.
         if (i_flush) sbq.delete();
         else begin
            if (a_ov && i_ready) begin
               chk("sb_nonempty", sbq.size() != 0, 1);
               if (sbq.size() != 0) begin head = sbq.pop_front(); chk("sb_order", a_pc, head); end
            end
            if (i_valid && a_ordy) sbq.push_back(i_pc);
         end
         for (int k = 0; k < 3; k++) begin
            h = haz(k); adv = !mv[k] || i_ready;
            if (i_flush) mv[k] = 0;
            else if (adv) begin
               if (i_valid && !h) begin mv[k] = 1; mo[k] = dec(i_instr, i_pc, ee[k]); icnt[k]++; end
               else begin mv[k] = 0; if (h) bcnt[k]++; end
            end
         end
      end
   end

   logic [31:0] pcn = 32'h1000;

   task automatic cyc(input logic v, input logic [31:0] ins, pc, input logic rdy, fl, output logic acc);
      i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
      @(negedge i_clk);
      acc = a_ordy && v && !fl;
      @(posedge i_clk); #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic rdy, output int tries);
      logic acc; acc = 0; tries = 0;
      while (!acc && tries < 16) begin cyc(1, ins, pcn, rdy, 0, acc); tries++; end
      if (!acc) chk("send_timeout", acc, 1);
      pcn += 4;
   endtask

   task automatic idle(input int n);
      logic acc;
      repeat (n) cyc(0, 32'h0, pcn, 1, 0, acc);
   endtask

   task automatic rst_pulse();
      i_valid = 0; i_flush = 0; i_ready = 1;
      #2 i_rst = 1;
      #1 chk("rst_async_valid", a_ov, 0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 0;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
      logic [31:0] r;
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) != 0) begin
         r[11:7] = 5'($urandom_range(0, 3)); r[19:15] = 5'($urandom_range(0, 3));
         r[24:20] = 5'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) r[19:15] = 5'd17;
      return r;
   endfunction

   localparam logic [31:0] ADDI = 32'hFFD08293, LW7 = 32'h00012383, ADD87 = 32'h00338433;
   localparam logic [31:0] LW0 = 32'h00012003, ADD80 = 32'h00300433, ADD17 = 32'h002088B3;

   initial begin
      logic acc; int t; dec_t dm; logic [31:0] r[4];
      i_rst = 1; i_valid = 0; i_flush = 0; i_ready = 1; i_instr = 0; i_pc = 0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 0;
      #1 chk("rst_ready", a_ordy, 1);
      chk("rst_valid_after", a_ov, 0);
      @(posedge i_clk); #1;

      dm = dec(ADDI, 0, 0);
      chk("model_addi_imm", dm.imm, 32'hFFFFFFFD);
      dm = dec(32'h0080006F, 0, 0);  // JAL x0, +8
      chk("model_jal_imm", dm.imm, 32'h8);
      dm = dec(32'hFE000EE3, 0, 0);  // BEQ x0,x0,-4
      chk("model_beq_imm", dm.imm, 32'hFFFFFFFC);

      send(ADDI, 1, t);
      chk("addi_valid", a_ov, 1);
      chk("addi_imm", a_imm, 32'hFFFFFFFD);
      chk("addi_ex", a_ex[13:10], 4'b1001);
      chk("addi_wb", a_wb, {2'b10, 5'd5});
      chk("addi_rs", {a_rs1, a_rs2}, {5'd1, 5'd0});
      idle(1);

      for (int i = 0; i < 4; i++) r[i] = {7'b0, 5'd2, 5'd1, 3'b0, 5'(10 + i), 7'b0110011};
      send(r[0], 1, t); send(r[1], 1, t);
      cyc(1, r[2], pcn, 0, 0, acc); chk("held_ready0", acc, 0);
      cyc(1, r[2], pcn, 0, 0, acc); chk("held_ready1", acc, 0);
      send(r[2], 1, t); send(r[3], 1, t);
      idle(2);

      send(LW7, 1, t);
      cyc(1, ADD87, pcn, 1, 0, acc); chk("lu_stall", acc, 0);
      chk("lu_bubble", a_ov, 0);
      chk("nolu_capture", {n_ov, n_wb[4:0]}, {1'b1, 5'd8});
      send(ADD87, 1, t); chk("lu_after_tries", t, 1);
      chk("lu_add_out", {a_ov, a_wb[4:0]}, {1'b1, 5'd8});
      send(LW0, 1, t); send(ADD80, 1, t); chk("x0_no_bubble", t, 1);
      idle(1);

      send(r[0], 0, t);
      chk("flush_pre_valid", a_ov, 1);
      cyc(1, r[1], pcn, 0, 1, acc); pcn += 4;
      chk("flush_valid", a_ov, 0);

      send(32'h0000007F, 1, t);
      chk("illegal_flag", {a_ov, a_ill}, 2'b11);
      chk("illegal_ctrl", {a_ex, a_mem, a_wb, a_rs1, a_rs2}, 0);
      send(ADD17, 1, t);
      chk("e_illegal_flag", {e_ov, e_ill}, 2'b11);
      chk("e_illegal_ctrl", {e_ex, e_mem, e_wb, e_rs1, e_rs2}, 0);
      chk("i_add17", {a_ill, a_wb}, {1'b0, 2'b10, 5'd17});

      idle(1);
      send(ADDI, 0, t);
      rst_pulse();

      send(LW7, 1, t); send(ADD87, 1, t); send(ADDI, 1, t); send(LW7, 1, t); send(ADD87, 1, t);
      repeat (5) send(ADDI, 1, t);
`ifdef ID_PERF_CNT_EN
      chk("perf_instr", a_ic, 10);
      chk("perf_bubble", a_bc, 2);
`endif
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) rst_pulse();
         cyc($urandom_range(0, 3) != 0, rnd_instr(), pcn, $urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0, acc);
         pcn += 4;
      end
      idle(3);
      chk("sb_drain", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
